// File: rtl/pcie_result_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : pcie_result_writer_if
// Description : Control, channel-stream and PCIe write-buffer signals of the
//               multi-channel result writer. The master side is the job
//               controller, result producers and buffer; the slave side is
//               the writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcie_result_writer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 14,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic                       cpu_pkt_done;
    logic [CNT_W-1:0]           total_num;
    logic                       read_done;
    logic [NUM_CH-1:0]          ch_vld;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [NUM_CH-1:0]          ch_rdy;
    logic [DATA_W-1:0]          data_write_pcie;
    logic [ADDR_W-1:0]          addr_write_pcie;
    logic                       en_write_pcie;
    logic                       max_data_num_done;
    logic                       data_done;

    modport master (
        output cpu_pkt_done, total_num, read_done, ch_vld, ch_data,
        input  ch_rdy, data_write_pcie, addr_write_pcie, en_write_pcie,
               max_data_num_done, data_done
    );

    modport slave (
        input  cpu_pkt_done, total_num, read_done, ch_vld, ch_data,
        output ch_rdy, data_write_pcie, addr_write_pcie, en_write_pcie,
               max_data_num_done, data_done
    );
endinterface
`default_nettype wire

// File: rtl/pcie_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : pcie_result_writer
// Description : Drains NUM_CH result streams into the PCIe write buffer using
//               round-robin arbitration, a batch address pointer and host
//               flow control (pause on buffer full until read_done).
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_result_writer #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 14,
    parameter int NUM_CH  = 4,
    parameter int MAX_NUM = 16384,
    parameter int CNT_W   = 32
) (
    input  wire logic           sys_clk,
    input  wire logic           sys_rst_n,
    pcie_result_writer_if.slave bus
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(MAX_NUM - 1);
    localparam logic [RR_W-1:0]   c_CH_LAST  = RR_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_FULL_WAIT = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_total;
    logic [RR_W-1:0]    r_rr_ptr;
    logic               r_en;
    logic [DATA_W-1:0]  r_data;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_full;
    logic               r_done;

    logic               w_any;
    logic [RR_W-1:0]    w_grant_idx;
    logic [RR_W:0]      w_idx;
    logic [NUM_CH-1:0]  w_rdy;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;
    logic               w_at_end;
    logic               w_start;
    logic [DATA_W-1:0]  w_sel_data;

    assign w_cnt_inc  = r_wr_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == r_total);
    assign w_at_end   = (r_wr_ptr == c_PTR_LAST);
    assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.cpu_pkt_done;
    assign w_sel_data = bus.ch_data[w_grant_idx*DATA_W +: DATA_W];

    // Round-robin search from r_rr_ptr; grants only while running
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        w_rdy       = '0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_idx = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
                if (w_idx >= (RR_W+1)'(NUM_CH)) begin
                    w_idx = w_idx - (RR_W+1)'(NUM_CH);
                end
                if (!w_any && bus.ch_vld[w_idx[RR_W-1:0]]) begin
                    w_any       = 1'b1;
                    w_grant_idx = w_idx[RR_W-1:0];
                end
            end
        end
        if (w_any) begin
            w_rdy = NUM_CH'(1) << w_grant_idx;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state; an exact buffer fill on the final word ends the job
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.cpu_pkt_done) begin
                    w_next = (bus.total_num == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_any) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else if (w_at_end) begin
                        w_next = S_FULL_WAIT;
                    end
                end
            end
            S_FULL_WAIT: begin
                if (bus.read_done) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Write pipeline, counters, arbiter pointer and status flags
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_wr_cnt <= '0;
            r_total  <= '0;
            r_rr_ptr <= '0;
            r_en     <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_en <= w_any;
            if (w_any) begin
                r_data   <= w_sel_data;
                r_addr   <= r_wr_ptr;
                r_wr_cnt <= w_cnt_inc;
                r_rr_ptr <= (w_grant_idx == c_CH_LAST) ? '0 : w_grant_idx + RR_W'(1);
                // The pointer parks on the last slot; only read_done rewinds it
                if (!w_at_end) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_last) begin
                    r_done <= 1'b1;
                end else if (w_at_end) begin
                    r_full <= 1'b1;
                end
            end
            if (w_start) begin
                r_total  <= bus.total_num;
                r_wr_ptr <= '0;
                r_wr_cnt <= '0;
                r_done   <= (bus.total_num == '0);
            end
            if ((r_state == S_FULL_WAIT) && bus.read_done) begin
                r_full   <= 1'b0;
                r_wr_ptr <= '0;
            end
        end
    end

    assign bus.ch_rdy            = w_rdy;
    assign bus.data_write_pcie   = r_data;
    assign bus.addr_write_pcie   = r_addr;
    assign bus.en_write_pcie     = r_en;
    assign bus.max_data_num_done = r_full;
    assign bus.data_done         = r_done;

endmodule
`default_nettype wire
